// File: rtl/run_control_pkg.sv
// run_control_pkg: FSM state and halt-cause encodings shared by run_control.
package run_control_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {
    HC_NONE    = 2'd0,
    HC_PC      = 2'd1,
    HC_ZERO    = 2'd2,
    HC_TIMEOUT = 2'd3
  } halt_cause_t;
endpackage

// File: rtl/run_cycle_counter.sv
// run_cycle_counter: saturating up-counter with synchronous clear and enable.
module run_cycle_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (clr) count <= '0;
    else if (en && count != MAX) count <= count + 1'b1;
endmodule

// File: rtl/run_control.sv
// run_control: IDLE/CLEAR/RUN/DONE run sequencer with PC, zero-run and optional watchdog halts.
// Define RUN_CONTROL_WATCHDOG_EN to enable the MAX_CYCLES timeout.
module run_control
  import run_control_pkg::*;
#(
  parameter int              PC_W       = 8,
  parameter int              INSTR_W    = 9,
  parameter logic [PC_W-1:0] HALT_PC    = '1,
  parameter int              ZERO_RUN   = 1,
  parameter int              CYC_W      = 16,
  parameter int              MAX_CYCLES = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] mach_code,
  output logic               core_clr,
  output logic               run_en,
  output logic               done,
  output logic [1:0]         halt_cause,
  output logic [CYC_W-1:0]   cycle_count
);
`ifdef RUN_CONTROL_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  state_t      state;
  halt_cause_t cause;
  logic [3:0]  zero_count;
  logic        in_run, in_clear, is_zero, pc_hit, zero_hit, timeout, halt;
  assign in_run   = state == S_RUN;
  assign in_clear = state == S_CLEAR;
  assign is_zero  = mach_code == '0;
  assign pc_hit   = in_run && pc == HALT_PC;
  // Halt on the instruction that completes the zero run, so it still executes.
  assign zero_hit = in_run && is_zero && ({1'b0, zero_count} + 5'd1 == 5'(ZERO_RUN));
  assign timeout  = WD_EN && MAX_CYCLES != 0 && in_run && cycle_count == CYC_W'(MAX_CYCLES - 1);
  assign halt     = pc_hit || zero_hit || timeout;
  assign cause    = pc_hit ? HC_PC : zero_hit ? HC_ZERO : HC_TIMEOUT;
  run_cycle_counter #(.W(CYC_W)) u_cycle (
    .clk   (clk),
    .reset (reset),
    .clr   (in_clear),
    .en    (in_run),
    .count (cycle_count)
  );
  run_cycle_counter #(.W(4), .MAX(4'(ZERO_RUN))) u_zero (
    .clk   (clk),
    .reset (reset),
    .clr   (in_clear || (in_run && !is_zero)),
    .en    (in_run && is_zero),
    .count (zero_count)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= S_IDLE;
      core_clr   <= 1'b0;
      run_en     <= 1'b0;
      done       <= 1'b0;
      halt_cause <= HC_NONE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state    <= S_CLEAR;
          core_clr <= 1'b1;
        end
        S_CLEAR: begin
          state      <= S_RUN;
          core_clr   <= 1'b0;
          run_en     <= 1'b1;
          halt_cause <= HC_NONE;
        end
        S_RUN: if (halt) begin
          state      <= S_DONE;
          run_en     <= 1'b0;
          done       <= 1'b1;
          halt_cause <= cause;
        end
        S_DONE: if (!start) begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_run_control.sv
// tb_run_control: directed scoreboard bench for run_control (two configurations).
module tb_run_control;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  pc = '0;
  logic [8:0]  mc = 9'h1;
  logic        a_clr, a_run, a_done, b_clr, b_run, b_done;
  logic [1:0]  a_hc, b_hc;
  logic [15:0] a_cc;
  logic [3:0]  b_cc;
  int          checks = 0;
  int          errors = 0;
  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  run_control #(.ZERO_RUN(3), .MAX_CYCLES(20)) dut_a (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .mach_code(mc),
    .core_clr(a_clr), .run_en(a_run), .done(a_done), .halt_cause(a_hc), .cycle_count(a_cc)
  );
  run_control #(.ZERO_RUN(1), .CYC_W(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .mach_code(mc),
    .core_clr(b_clr), .run_en(b_run), .done(b_done), .halt_cause(b_hc), .cycle_count(b_cc)
  );
  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask
  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed 0x%0h with no expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.val);
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    pc = '0;
    mc = 9'h1;
    step();
    step();
    reset = 1'b1;
    step();
  endtask
  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask
  initial begin : watchdog
    #200000;
    $display("FAIL sim_timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    logic [8:0] zseq [6] = '{9'd0, 9'd0, 9'd5, 9'd0, 9'd0, 9'd0};
    // Reset state
    step();
    step();
    push("rst_clr", 0); push("rst_run", 0); push("rst_done", 0); push("rst_hc", 0); push("rst_cc", 0);
    check(a_clr); check(a_run); check(a_done); check(a_hc); check(a_cc);
    // PC halt at RUN cycle 10
    reset = 1'b1;
    step();
    start = 1'b1;
    step();
    push("clear_clr", 1); push("clear_run", 0);
    check(a_clr); check(a_run);
    start = 1'b0;
    step();
    push("run0_clr", 0); push("run0_run", 1);
    check(a_clr); check(a_run);
    for (int k = 0; k < 10; k++) begin
      pc = 8'(k);
      step();
    end
    push("run10_run", 1); push("run10_done", 0); push("run10_cc", 10);
    check(a_run); check(a_done); check(a_cc);
    pc = 8'hFF;
    push("pc_done", 1); push("pc_run", 0); push("pc_hc", 1); push("pc_cc", 11);
    step();
    check(a_done); check(a_run); check(a_hc); check(a_cc);
    pc = '0;
    push("idle_done", 0); push("idle_hc", 1); push("idle_cc", 11);
    step();
    check(a_done); check(a_hc); check(a_cc);
    // Zero run of 3 with an interrupting non-zero word
    do_reset();
    launch();
    for (int i = 0; i < 6; i++) begin
      mc = zseq[i];
      if (i == 4) begin push("zero5_done", 0); push("zero5_run", 1); end
      if (i == 5) begin push("zero_done", 1); push("zero_hc", 2); push("zero_cc", 6); end
      step();
      if (i == 4) begin check(a_done); check(a_run); end
      if (i == 5) begin check(a_done); check(a_hc); check(a_cc); end
    end
    // Watchdog at 20 RUN cycles; dut_b cycle counter saturates
    do_reset();
    launch();
    repeat (20) step();
`ifdef RUN_CONTROL_WATCHDOG_EN
    push("wd_done", 1); push("wd_run", 0); push("wd_hc", 3); push("wd_cc", 20);
    check(a_done); check(a_run); check(a_hc); check(a_cc);
`else
    push("nowd_done", 0); push("nowd_run", 1); push("nowd_cc", 20);
    check(a_done); check(a_run); check(a_cc);
    repeat (5) step();
    push("nowd_cc25", 25); push("nowd_run25", 1);
    check(a_cc); check(a_run);
`endif
    push("sat_cc", 15); push("sat_run", 1);
    check(b_cc); check(b_run);
    // Async reset mid-RUN
    do_reset();
    launch();
    repeat (5) step();
    push("mid_cc", 5);
    check(a_cc);
    reset = 1'b0;
    #1;
    push("arst_run", 0); push("arst_clr", 0); push("arst_done", 0); push("arst_hc", 0); push("arst_cc", 0);
    check(a_run); check(a_clr); check(a_done); check(a_hc); check(a_cc);
    step();
    reset = 1'b1;
    step();
    step();
    push("nostart_clr", 0); push("nostart_run", 0);
    check(a_clr); check(a_run);
    // start held high through DONE must not restart
    start = 1'b1;
    pc = 8'hFF;
    step();
    step();
    step();
    repeat (3) step();
    push("hold_done", 1); push("hold_clr", 0); push("hold_run", 0);
    check(a_done); check(a_clr); check(a_run);
    start = 1'b0;
    pc = '0;
    step();
    push("drop_done", 0);
    check(a_done);
    start = 1'b1;
    step();
    push("restart_clr", 1);
    check(a_clr);
    start = 1'b0;
    // PC and zero in the same cycle with ZERO_RUN=1: PC wins
    do_reset();
    launch();
    pc = 8'hFF;
    mc = '0;
    step();
    push("prio_done", 1); push("prio_hc", 1); push("prio_cc", 1);
    check(b_done); check(b_hc); check(b_cc);
    do_reset();
    launch();
    mc = '0;
    step();
    push("z1_done", 1); push("z1_hc", 2); push("a_single_zero_done", 0);
    check(b_done); check(b_hc); check(a_done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/run_control.md
RUN_CONTROL -- requirements
Module: run_control

Interface
- REQ-001: Parameter PC_W, default 8, program-counter width.
- REQ-002: Parameter INSTR_W, default 9, machine-code width.
- REQ-003: Parameter HALT_PC, default all-ones of PC_W, PC value that ends a run.
- REQ-004: Parameter ZERO_RUN, default 1 (range 1..15), number of consecutive all-zero instructions that ends a run.
- REQ-005: Parameter CYC_W, default 16, cycle-counter width.
- REQ-006: Parameter MAX_CYCLES, default 0 (0 = watchdog disabled), number of RUN cycles after which the run is aborted.
- REQ-007: clk  input  1  single clock; all state on rising edge.
- REQ-008: reset  input  1  asynchronous, active-low reset.
- REQ-009: start  input  1  level request to begin a run.
- REQ-010: pc  input  PC_W  current program counter from core.
- REQ-011: mach_code  input  INSTR_W  instruction currently fetched.
- REQ-012: core_clr  output  1  one-cycle synchronous clear to PC and register file.
- REQ-013: run_en  output  1  enables PC advance and all core write enables.
- REQ-014: done  output  1  run finished; held until start deasserts.
- REQ-015: halt_cause  output  2  NONE=0, PC=1, ZERO=2, TIMEOUT=3.
- REQ-016: cycle_count  output  CYC_W  RUN cycles in the current/last run.

Function
- REQ-017: The FSM SHALL have states IDLE, CLEAR, RUN, DONE.
- REQ-018: IDLE: run_en=0, core_clr=0, done=0; start=1 -> CLEAR next edge.
- REQ-019: CLEAR lasts exactly one cycle: core_clr=1, cycle_count<=0, zero counter<=0, halt_cause<=NONE; -> RUN.
- REQ-020: RUN: run_en=1; cycle_count increments each RUN cycle, saturating at all-ones.
- REQ-021: Zero counter increments on each RUN cycle with mach_code==0, clears on any non-zero mach_code, saturates at ZERO_RUN.
- REQ-022: Halt conditions are evaluated combinationally in RUN: PC when pc==HALT_PC; ZERO when zero counter+1==ZERO_RUN and mach_code==0; TIMEOUT when MAX_CYCLES!=0 and cycle_count==MAX_CYCLES-1.
- REQ-023: Any halt condition in cycle t SHALL move to DONE at t+1; the instruction at cycle t still executes (run_en=1 in t), run_en=0 from t+1.
- REQ-024: Simultaneous halt conditions SHALL record priority PC > ZERO > TIMEOUT in halt_cause.
- REQ-025: DONE: done=1, run_en=0, cycle_count and halt_cause held; start=0 -> IDLE; start held 1 SHALL NOT restart.
- REQ-026: start deassertion during CLEAR or RUN SHALL be ignored.
- REQ-027: halt_cause and cycle_count SHALL remain readable in IDLE until the next CLEAR.

Reset
- REQ-028: reset=0 SHALL asynchronously force IDLE, run_en=0, core_clr=0, done=0, halt_cause=NONE, cycle_count=0, zero counter=0, including mid-RUN.
- REQ-029: After reset release, the first CLEAR requires start sampled high in IDLE.

Configuration
- REQ-030: Macro RUN_CONTROL_WATCHDOG_EN defined: TIMEOUT detection per REQ-022 active.
- REQ-031: Macro undefined: watchdog logic absent, MAX_CYCLES ignored, halt_cause never TIMEOUT, runs end only on PC or ZERO.

Structure
- REQ-032: Package run_control_pkg SHALL hold the FSM state enum and the halt_cause enum.
- REQ-033: Saturating counter SHALL be sub-module run_cycle_counter (width parameter, clear, enable, saturate), instantiated for cycle_count and zero counter.

Verification
- REQ-034: Reset, start=1 one cycle -> core_clr=1 for exactly 1 cycle, then run_en=1; pc reaching 8'hFF at RUN cycle 10 -> done=1 next cycle, halt_cause=1, cycle_count=11.
- REQ-035: ZERO_RUN=3, mach_code 0,0,5,0,0,0 -> DONE only after third consecutive zero, halt_cause=2.
- REQ-036: Watchdog enabled, MAX_CYCLES=20, no halt -> done after 20 RUN cycles, halt_cause=3, cycle_count=20; macro undefined -> run continues past 20.
- REQ-037: pc==HALT_PC and mach_code==0 same cycle with ZERO_RUN=1 -> halt_cause=1.
- REQ-038: reset low at RUN cycle 5 -> all outputs zero immediately, IDLE; start held high through DONE -> no second run until start drops and rises.
